// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core.
package pipe_pkg;
   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_t;
endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised payload register with load enable and synchronous clear.
module pipe_payload_reg #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   // Clear wins over load so a flush can never leave a stale entry behind.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= d;
   end
endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid,
// synchronous flush and a saturating backpressure counter.
//
// state    | meaning
// ---------+-----------------------------------------
// ST_EMPTY | main and skid invalid
// ST_BUSY  | main valid (presented downstream), skid empty
// ST_FULL  | main and skid valid, no input accepted
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W       = XLEN,
   parameter int NUM_DATA     = 2,
   parameter int RD_W         = REG_IDX_W,
   parameter int CTRL_W       = 32,
   parameter int CNT_W        = 16,
   parameter int ZERO_INVALID = 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [CTRL_W-1:0]          in_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [RD_W-1:0]            out_rd,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [CNT_W-1:0]           stall_count
);
   localparam int  DW = NUM_DATA*DATA_W;
   localparam int  PW = DW + RD_W + CTRL_W;
   localparam bit  ZI = (ZERO_INVALID != 0);

   pipe_state_t   state, state_nxt;
   logic          accept;
   logic          main_en, main_clr, skid_en, skid_clr;
   logic [PW-1:0] in_pl, main_d, main_q, skid_q;

   assign in_pl  = {in_ctrl, in_rd, in_data};
   assign accept = in_valid & in_ready;
   assign main_d = (state == ST_FULL) ? skid_q : in_pl;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_EMPTY;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != ST_FULL);
      end
   end

   always_comb begin
      state_nxt = state;
      main_en   = 1'b0;
      main_clr  = 1'b0;
      skid_en   = 1'b0;
      skid_clr  = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
         main_clr  = ZI;
         skid_clr  = ZI;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt = ST_BUSY;
                  main_en   = 1'b1;
               end
            end
            ST_BUSY: begin
               if (accept && out_ready) begin
                  main_en = 1'b1;
               end else if (accept) begin
                  state_nxt = ST_FULL;
                  skid_en   = 1'b1;
               end else if (out_ready) begin
                  // Draining: clearing main keeps the idle payload at zero.
                  state_nxt = ST_EMPTY;
                  main_clr  = ZI;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  state_nxt = ST_BUSY;
                  main_en   = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   pipe_payload_reg #(.W(PW)) u_main (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (main_en),
      .clr     (main_clr),
      .d       (main_d),
      .q       (main_q)
   );

   pipe_payload_reg #(.W(PW)) u_skid (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (skid_en),
      .clr     (skid_clr),
      .d       (in_pl),
      .q       (skid_q)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_count <= '0;
      else if (out_valid && !out_ready && !flush && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q[DW-1:0];
   assign out_rd    = main_q[DW +: RD_W];
   assign out_ctrl  = main_q[DW+RD_W +: CTRL_W];
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances share one handshake stream and are
// compared against a 2-deep FIFO reference model.
module tb_pipe_stage_skid;
   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_data128 = '0;
   logic [4:0]   in_rd = '0;
   logic [31:0]  in_ctrl = '0;

   logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
   logic [63:0]  a_out_data;
   logic [31:0]  b_out_data;
   logic [127:0] c_out_data;
   logic [4:0]   a_out_rd, b_out_rd, c_out_rd;
   logic [31:0]  a_out_ctrl, b_out_ctrl, c_out_ctrl;
   logic [3:0]   a_stall;
   logic [15:0]  b_stall, c_stall;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   pipe_stage_skid #(.DATA_W(32), .NUM_DATA(2), .RD_W(5), .CTRL_W(32), .CNT_W(4), .ZERO_INVALID(1)) u_a (
      .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_data(in_data128[63:0]), .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_data(a_out_data), .out_rd(a_out_rd), .out_ctrl(a_out_ctrl),
      .stall_count(a_stall));

   pipe_stage_skid #(.DATA_W(32), .NUM_DATA(1), .RD_W(5), .CTRL_W(32), .CNT_W(16), .ZERO_INVALID(0)) u_b (
      .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_data(in_data128[31:0]), .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_data(b_out_data), .out_rd(b_out_rd), .out_ctrl(b_out_ctrl),
      .stall_count(b_stall));

   pipe_stage_skid #(.DATA_W(32), .NUM_DATA(4), .RD_W(5), .CTRL_W(32), .CNT_W(16), .ZERO_INVALID(0)) u_c (
      .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_data(in_data128), .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_data(c_out_data), .out_rd(c_out_rd), .out_ctrl(c_out_ctrl),
      .stall_count(c_stall));

   // Reference model: an ordered queue of at most two entries {ctrl, rd, data128}.
   logic [164:0] mq [2];
   int           mn = 0;
   bit           m_rdy = 1'b0;
   int           m_cnt = 0;
   logic [164:0] m_last = '0;

   function automatic logic [164:0] exp_pl(input bit zi);
      if (mn > 0) return mq[0];
      else if (zi) return '0;
      else return m_last;
   endfunction

   function automatic logic [3:0] sat4();
      return (m_cnt > 15) ? 4'd15 : m_cnt[3:0];
   endfunction

   function automatic logic [15:0] sat16();
      return (m_cnt > 65535) ? 16'hFFFF : m_cnt[15:0];
   endfunction

   task automatic model_reset();
      mn = 0; m_rdy = 1'b0; m_cnt = 0; m_last = '0;
      mq[0] = '0; mq[1] = '0;
   endtask

   // Advance the model with the inputs the DUT sees at the coming edge, then wait for it.
   task automatic step();
      logic [164:0] pl;
      bit fo, fi;
      pl = {in_ctrl, in_rd, in_data128};
      if (flush) begin
         mn = 0;
      end else begin
         fo = (mn > 0) && out_ready;
         fi = in_valid && m_rdy;
         if (mn > 0 && !out_ready) m_cnt++;
         if (fo) begin mq[0] = mq[1]; mn--; end
         if (fi) begin mq[mn] = pl; mn++; end
      end
      m_rdy = (mn < 2);
      if (mn > 0) m_last = mq[0];
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      reset_n = 1'b0;
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic drive(input logic [31:0] w0, input logic [4:0] rd);
      in_valid   = 1'b1;
      in_data128 = {$urandom, $urandom, $urandom, w0};
      in_rd      = rd;
      in_ctrl    = $urandom;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({a_out_valid, a_in_ready, b_out_valid, c_in_ready} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b want 0000", {a_out_valid, a_in_ready, b_out_valid, c_in_ready});
      end
      checks++;
      if ({a_out_data, a_out_rd, a_out_ctrl, a_stall, c_out_data} !== '0) begin
         errors++; $display("FAIL reset_payload got a=%h c=%h want 0", a_out_data, c_out_data);
      end
      @(negedge clock);
      reset_n = 1'b1;
      step();
      checks++;
      if ({a_in_ready, b_in_ready, c_in_ready, a_out_valid} !== 4'b1110) begin
         errors++; $display("FAIL reset_release got %b want 1110", {a_in_ready, b_in_ready, c_in_ready, a_out_valid});
      end
   endtask

   task automatic test_stream();
      logic [164:0] e;
      do_reset(); step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(32'h11 * (i + 1), 5'(i + 1));
         step();
         e = exp_pl(1'b1);
         checks++;
         if ({a_out_valid, a_out_data[31:0], a_out_rd} !== {1'b1, 32'h11 * (i + 1), 5'(i + 1)}) begin
            errors++; $display("FAIL stream_%0d got v=%b d=%h rd=%0d want v=1 d=%h rd=%0d",
                               i, a_out_valid, a_out_data[31:0], a_out_rd, 32'h11 * (i + 1), i + 1);
         end
         checks++;
         if ({a_out_data, a_out_ctrl, c_out_data} !== {e[63:0], e[164:133], e[127:0]}) begin
            errors++; $display("FAIL stream_pl_%0d got a=%h c=%h want a=%h c=%h", i, a_out_data, c_out_data, e[63:0], e[127:0]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if ({a_out_valid, a_out_data, b_out_data} !== {1'b0, 64'h0, 32'h44}) begin
         errors++; $display("FAIL stream_drain got v=%b a=%h b=%h want v=0 a=0 b=44", a_out_valid, a_out_data, b_out_data);
      end
   endtask

   task automatic test_backpressure();
      do_reset(); step();
      out_ready = 1'b0;
      drive(32'hA, 5'd1); step();
      drive(32'hB, 5'd2); step();
      in_valid = 1'b0; step(); step();
      checks++;
      if ({a_in_ready, a_out_valid, a_out_data[31:0], a_stall} !== {1'b0, 1'b1, 32'hA, 4'd3}) begin
         errors++; $display("FAIL bp_full got rdy=%b v=%b d=%h stall=%0d want rdy=0 v=1 d=a stall=3",
                            a_in_ready, a_out_valid, a_out_data[31:0], a_stall);
      end
      checks++;
      if ({b_stall, c_stall} !== {sat16(), sat16()}) begin
         errors++; $display("FAIL bp_stall got b=%0d c=%0d want %0d", b_stall, c_stall, sat16());
      end
      out_ready = 1'b1; step();
      checks++;
      if ({a_in_ready, a_out_valid, a_out_data[31:0], a_out_rd} !== {1'b1, 1'b1, 32'hB, 5'd2}) begin
         errors++; $display("FAIL bp_second got rdy=%b v=%b d=%h rd=%0d want rdy=1 v=1 d=b rd=2",
                            a_in_ready, a_out_valid, a_out_data[31:0], a_out_rd);
      end
      step();
      checks++;
      if ({a_out_valid, a_stall} !== {1'b0, 4'd3}) begin
         errors++; $display("FAIL bp_empty got v=%b stall=%0d want v=0 stall=3", a_out_valid, a_stall);
      end
   endtask

   task automatic test_flush();
      do_reset(); step();
      out_ready = 1'b0;
      drive(32'hA, 5'd1); step();
      drive(32'hB, 5'd2); step();
      drive(32'hC, 5'd3);
      flush = 1'b1;
      step();
      checks++;
      if ({a_out_valid, a_in_ready, a_out_data, a_out_rd, a_out_ctrl, a_stall} !== {1'b0, 1'b1, 101'h0, 4'd1}) begin
         errors++; $display("FAIL flush_zero got v=%b rdy=%b d=%h stall=%0d want v=0 rdy=1 d=0 stall=1",
                            a_out_valid, a_in_ready, a_out_data, a_stall);
      end
      checks++;
      if ({b_out_valid, b_out_data, b_out_rd} !== {1'b0, 32'hA, 5'd1}) begin
         errors++; $display("FAIL flush_hold got v=%b d=%h rd=%0d want v=0 d=a rd=1", b_out_valid, b_out_data, b_out_rd);
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (a_out_valid !== 1'b0 || b_out_data === 32'hC || a_out_data[31:0] === 32'hC) begin
            errors++; $display("FAIL flush_gone_%0d got v=%b a=%h b=%h want v=0 and no c", i, a_out_valid, a_out_data, b_out_data);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset(); step();
      out_ready = 1'b0;
      drive(32'h5A, 5'd7); step();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if ({a_stall, b_stall} !== {sat4(), sat16()}) begin
            errors++; $display("FAIL sat_%0d got a=%0d b=%0d want a=%0d b=%0d", i, a_stall, b_stall, sat4(), sat16());
         end
      end
      checks++;
      if ({a_stall, b_stall, a_out_valid} !== {4'd15, 16'd20, 1'b1}) begin
         errors++; $display("FAIL sat_final got a=%0d b=%0d v=%b want a=15 b=20 v=1", a_stall, b_stall, a_out_valid);
      end
   endtask

   task automatic test_param_sweep();
      logic [127:0] d;
      logic [4:0]   r;
      logic [31:0]  c;
      do_reset(); step();
      out_ready = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom}; r = 5'($urandom); c = $urandom;
      in_valid = 1'b1; in_data128 = d; in_rd = r; in_ctrl = c;
      step();
      checks++;
      if ({c_out_data, c_out_rd, c_out_ctrl, b_out_data} !== {d, r, c, d[31:0]}) begin
         errors++; $display("FAIL sweep_route got c=%h b=%h want c=%h b=%h", c_out_data, b_out_data, d, d[31:0]);
      end
      in_valid = 1'b0; in_data128 = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({c_out_valid, c_out_data, c_out_rd, c_out_ctrl, b_out_data, a_out_data} !== {1'b0, d, r, c, d[31:0], 64'h0}) begin
            errors++; $display("FAIL sweep_hold_%0d got v=%b c=%h b=%h a=%h want v=0 c=%h b=%h a=0",
                               i, c_out_valid, c_out_data, b_out_data, a_out_data, d, d[31:0]);
         end
      end
   endtask

   task automatic test_random();
      logic [164:0] ea, eb;
      do_reset(); step();
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 9) < 7);
         out_ready  = ($urandom_range(0, 9) < 6);
         flush      = ($urandom_range(0, 15) == 0);
         in_data128 = {$urandom, $urandom, $urandom, $urandom};
         in_rd      = 5'($urandom);
         in_ctrl    = $urandom;
         step();
         ea = exp_pl(1'b1);
         eb = exp_pl(1'b0);
         checks++;
         if ({a_out_valid, a_in_ready, a_out_data, a_out_rd, a_out_ctrl, a_stall} !==
             {(mn > 0), m_rdy, ea[63:0], ea[132:128], ea[164:133], sat4()}) begin
            errors++; $display("FAIL rand_a_%0d got v=%b r=%b d=%h rd=%h c=%h s=%0d want v=%b r=%b d=%h rd=%h c=%h s=%0d",
                               i, a_out_valid, a_in_ready, a_out_data, a_out_rd, a_out_ctrl, a_stall,
                               (mn > 0), m_rdy, ea[63:0], ea[132:128], ea[164:133], sat4());
         end
         checks++;
         if ({b_out_valid, b_in_ready, b_out_data, b_out_rd, b_out_ctrl, b_stall,
              c_out_valid, c_in_ready, c_out_data, c_out_rd, c_out_ctrl, c_stall} !==
             {(mn > 0), m_rdy, eb[31:0], eb[132:128], eb[164:133], sat16(),
              (mn > 0), m_rdy, eb[127:0], eb[132:128], eb[164:133], sat16()}) begin
            errors++; $display("FAIL rand_bc_%0d got b=%h c=%h sb=%0d want b=%h c=%h s=%0d",
                               i, b_out_data, c_out_data, b_stall, eb[31:0], eb[127:0], sat16());
         end
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      do_reset(); step();
      out_ready = 1'b0;
      drive(32'h77, 5'd9); step();
      drive(32'h88, 5'd10); step();
      in_valid = 1'b0;
      checks++;
      if ({a_in_ready, a_out_valid} !== 2'b01) begin
         errors++; $display("FAIL mid_full got rdy=%b v=%b want rdy=0 v=1", a_in_ready, a_out_valid);
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_data, a_out_rd, a_out_ctrl, a_stall, c_out_data, b_stall} !== '0) begin
         errors++; $display("FAIL mid_async got v=%b r=%b a=%h c=%h s=%0d want all 0",
                            a_out_valid, a_in_ready, a_out_data, c_out_data, a_stall);
      end
      @(negedge clock);
      reset_n = 1'b1;
      step();
      checks++;
      if ({a_in_ready, a_out_valid, a_stall} !== {1'b1, 1'b0, 4'd0}) begin
         errors++; $display("FAIL mid_release got r=%b v=%b s=%0d want r=1 v=0 s=0", a_in_ready, a_out_valid, a_stall);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_saturation();
      test_param_sweep();
      test_random();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM latch: a generic inter-stage pipeline register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries NUM_DATA data words, a destination register index and a control word.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure from the downstream stage never drops an instruction and throughput stays at one per cycle.
- Adds synchronous flush for branch/exception squash and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 32, width of each data word.
- NUM_DATA, 2, number of data words per entry (1..4).
- RD_W, 5, destination register index width.
- CTRL_W, 32, control word width.
- CNT_W, 16, stall counter width.
- ZERO_INVALID, 1, 1 = payload outputs forced to 0 when out_valid=0; 0 = payload holds its last value.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered.
- in_data  in  NUM_DATA*DATA_W  packed data words; word 0 in the LSBs.
- in_rd  in  RD_W  destination register index.
- in_ctrl  in  CTRL_W  control word.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_DATA*DATA_W  packed data words.
- out_rd  out  RD_W  destination register index.
- out_ctrl  out  CTRL_W  control word.
- stall_count  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=EMPTY; out_valid=0; in_ready=0.
  - out_data/out_rd/out_ctrl=0; skid contents=0; stall_count=0.
  - in_ready rises to 1 on the first clock edge after reset_n deasserts.
- Handshakes:
  - Input accepted when in_valid & in_ready at a clock edge.
  - Output consumed when out_valid & out_ready.
  - Latency through an empty stage: 1 cycle.
- States:
  - EMPTY: main and skid invalid.
  - BUSY: main valid, skid empty.
  - FULL: main and skid both valid.
- Transitions (at the edge, flush=0):
  - EMPTY: accept -> BUSY, main<=in.
  - BUSY: accept & out_ready -> BUSY, main<=in. Accept & !out_ready -> FULL, skid<=in. No accept & out_ready -> EMPTY. Otherwise hold.
  - FULL: out_ready -> BUSY, main<=skid. Otherwise hold. No input is accepted in FULL.
- in_ready is registered as (next_state != FULL). It is therefore never combinationally dependent on out_ready.
- out_valid = (state != EMPTY); the output payload comes from main.
- Downstream stability: while out_valid=1 & out_ready=0, the output payload must not change.
- Flush:
  - Synchronous; highest priority below reset.
  - Next state EMPTY; both entries invalidated.
  - An input handshake in the same cycle is discarded.
  - in_ready=1 the following cycle.
  - If ZERO_INVALID=1, the payload registers are cleared.
- stall_count:
  - Increments each cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- ZERO_INVALID=0: the payload keeps its last value after the stage drains. This is only legal where downstream qualifies on out_valid.
- Width rules: all payload fields are passed bit-exact with no arithmetic. The counter adds with saturation.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2;
  - default widths XLEN=32 and REG_IDX_W=5, reused by all stage instances.
- Natural sub-module: pipe_payload_reg, a width-parametrised enable/clear register with async active-low reset.
  - It is instanced twice (main, skid) with payload width NUM_DATA*DATA_W+RD_W+CTRL_W.
  - The FSM and counter stay in the top module.

Test Plan:
- Reset: hold reset_n=0 mid-stream with state FULL -> all outputs 0 and state EMPTY immediately, without waiting for a clock edge; in_ready=1 one edge after release.
- Streaming: out_ready=1, four back-to-back inputs with in_data word0 = 32'h11, 32'h22, 32'h33, 32'h44 and rd 1..4 -> out_valid each cycle from cycle 1; outputs in order, 1-cycle latency.
- Backpressure: send A=32'hA, B=32'hB, then drop out_ready for 3 cycles -> state FULL, in_ready=0, out_data holds A, stall_count=3. On out_ready=1: A, then B; in_ready returns to 1.
- Flush: state FULL with in_valid=1 (C=32'hC) and flush=1 -> next cycle out_valid=0 and out_data=0 (ZERO_INVALID=1); C never appears; stall_count unchanged.
- Saturation: CNT_W=4, out_ready=0 for 20 cycles with an entry held -> stall_count stops at 15.
- Parameter sweep: NUM_DATA=1 and NUM_DATA=4 with ZERO_INVALID=0 -> packed words routed bit-exact; payload holds the last value after the stage drains.
